// File: rtl/bcd_pkg.sv
// Purpose : shared constants, FSM state encoding and helpers for the BCD-to-binary converters.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: BCD_DIGIT_W, state_t {IDLE, OP, DONE}, min_bin_w(), digit_valid().
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest binary width able to hold 10^n - 1, i.e. ceil(log2(10^n)).
  // A 128-bit accumulator keeps the power of ten exact for any practical digit count.
  function automatic int min_bin_w(input int n);
    logic [127:0] p;
    int           w;
    p = 128'd1;
    for (int i = 0; i < n; i++) p = p * 128'd10;
    w = 0;
    for (int k = 0; k < 128; k++) begin
      if ((128'd1 << w) < p) w = w + 1;
    end
    return w;
  endfunction

  function automatic logic digit_valid(input logic [BCD_DIGIT_W-1:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Purpose : per-digit correction for reverse double-dabble; subtracts 3 from a digit >= 8.
// Latency : combinational, zero cycles.
// Backpressure: none (pure function).
// Ports   : i_dig - shifted BCD digit, o_dig - corrected digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_dig,
  output logic [BCD_DIGIT_W-1:0] o_dig
);

  // A digit reads >= 8 only when the LSB of the next-higher digit moved into its MSB.
  // That bit is worth 5 in this position but reads as 8, hence the -3 correction.
  assign o_dig = (i_dig >= 4'd8) ? (i_dig - 4'd3) : i_dig;

endmodule

// File: rtl/bcd2bin_n.sv
// Purpose : iterative N-digit BCD-to-binary converter (reverse double-dabble) with invalid-digit flag.
// Latency : start accepted at edge t -> done_tick in cycle t+BIN_W+1; invalid digit -> t+1.
// Backpressure: start honoured only while ready=1; starts while busy are dropped, not queued.
// Ports   : clk, reset (async, active-high), start, bcd (packed digits, digit 0 = LSD),
//           ready (IDLE), done_tick (1-cycle result strobe), bin (result), err (digit > 9 seen).
module bcd2bin_n
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int BIN_W    = 14
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [BCD_DIGIT_W*N_DIGITS-1:0] bcd,
  output logic                            ready,
  output logic                            done_tick,
  output logic [BIN_W-1:0]                bin,
  output logic                            err
);

  localparam int BCD_W = BCD_DIGIT_W * N_DIGITS;
  localparam int CNT_W = $clog2(BIN_W);

  generate
    if (BIN_W < min_bin_w(N_DIGITS)) begin : g_bin_w_too_small
      $error("bcd2bin_n: BIN_W=%0d cannot hold %0d BCD digits (needs %0d)",
             BIN_W, N_DIGITS, min_bin_w(N_DIGITS));
    end
  endgenerate

  state_t             r_state;
  state_t             w_state_next;
  logic [BCD_W-1:0]   r_bcd;
  logic [BCD_W-1:0]   w_bcd_next;
  logic [BIN_W-1:0]   r_bin;
  logic [BIN_W-1:0]   w_bin_next;
  logic [CNT_W-1:0]   r_n;
  logic [CNT_W-1:0]   w_n_next;
  logic               r_err;
  logic               w_err_next;

  logic [BCD_W+BIN_W-1:0] w_shift;
  logic [BCD_W-1:0]       w_shift_bcd;
  logic [BIN_W-1:0]       w_shift_bin;
  logic [BCD_W-1:0]       w_adj_bcd;
  logic [N_DIGITS-1:0]    w_digit_bad;
  logic                   w_any_bad;

  // One right shift of the concatenated register pair per OP cycle; the BCD
  // LSB falls into the binary MSB, so after BIN_W shifts bin holds the value.
  assign w_shift     = {r_bcd, r_bin} >> 1;
  assign w_shift_bcd = w_shift[BCD_W+BIN_W-1:BIN_W];
  assign w_shift_bin = w_shift[BIN_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      bcd_digit_adj u_adj (
        .i_dig (w_shift_bcd[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .o_dig (w_adj_bcd[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
      assign w_digit_bad[gi] = ~digit_valid(bcd[gi*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end
  endgenerate

  assign w_any_bad = |w_digit_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_bcd_next   = r_bcd;
    w_bin_next   = r_bin;
    w_n_next     = r_n;
    w_err_next   = r_err;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_bcd_next = bcd;
          w_bin_next = '0;
          w_n_next   = CNT_W'(BIN_W - 1);
          w_err_next = 1'b0;
          // A bad digit skips the conversion entirely and reports through err.
          if (w_any_bad) begin
            w_err_next   = 1'b1;
            w_state_next = DONE;
          end else begin
            w_state_next = OP;
          end
        end
      end
      OP: begin
        w_bcd_next = w_adj_bcd;
        w_bin_next = w_shift_bin;
        // Counter saturates at zero; the exit is taken on the last iteration.
        if (r_n == '0) begin
          w_state_next = DONE;
        end else begin
          w_n_next = r_n - CNT_W'(1);
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bcd <= '0;
      r_bin <= '0;
      r_n   <= '0;
      r_err <= 1'b0;
    end else begin
      r_bcd <= w_bcd_next;
      r_bin <= w_bin_next;
      r_n   <= w_n_next;
      r_err <= w_err_next;
    end
  end

  // Outputs come from registers only, so no path from start/bcd to any output.
  assign ready     = (r_state == IDLE);
  assign done_tick = (r_state == DONE);
  assign bin       = r_bin;
  assign err       = r_err;

endmodule

// File: tb/tb_bcd2bin_n.sv
// Purpose : scoreboard bench for bcd2bin_n at three digit widths (4/14, 2/7, 6/20).
// Latency : expected done at issue_cycle + BIN_W + 1 (valid) or + 1 (invalid digit).
// Backpressure: drivers wait for ready before issuing; extra starts while busy must be dropped.
module tb_bcd2bin_n;

  typedef struct {
    int unsigned bin;
    bit          err;
    int          issue;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  logic        a_start, a_rdy, a_done, a_err;
  logic [15:0] a_bcd;
  logic [13:0] a_bin;
  logic        b_start, b_rdy, b_done, b_err;
  logic [7:0]  b_bcd;
  logic [6:0]  b_bin;
  logic        c_start, c_rdy, c_done, c_err;
  logic [23:0] c_bcd;
  logic [19:0] c_bin;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  int n_cmp = 0;
  int n_bad = 0;
  int a_ndone = 0;
  int a_npush = 0;
  int b_last = -1;
  bit a_chk_rdy = 1'b0;

  bcd2bin_n #(.N_DIGITS(4), .BIN_W(14)) u_dut_a (
    .clk(clk), .reset(reset), .start(a_start), .bcd(a_bcd),
    .ready(a_rdy), .done_tick(a_done), .bin(a_bin), .err(a_err)
  );

  bcd2bin_n #(.N_DIGITS(2), .BIN_W(7)) u_dut_b (
    .clk(clk), .reset(reset), .start(b_start), .bcd(b_bcd),
    .ready(b_rdy), .done_tick(b_done), .bin(b_bin), .err(b_err)
  );

  bcd2bin_n #(.N_DIGITS(6), .BIN_W(20)) u_dut_c (
    .clk(clk), .reset(reset), .start(c_start), .bcd(c_bcd),
    .ready(c_rdy), .done_tick(c_done), .bin(c_bin), .err(c_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Waits (from a negedge) until the selected DUT is ready; returns 0 on timeout.
  task automatic wait_ready(input int sel, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if ((sel == 0 && a_rdy) || (sel == 1 && b_rdy) || (sel == 2 && c_rdy)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) fail_event("ready_timeout");
  endtask

  // Issues one conversion and pushes its hand-computed expectation.
  task automatic conv(input int sel, input logic [23:0] b, input int unsigned eb, input bit ee);
    exp_t e;
    bit   ok;
    wait_ready(sel, ok);
    if (!ok) return;
    e.bin   = eb;
    e.err   = ee;
    e.issue = cyc;
    e.lat   = ee ? 1 : ((sel == 0) ? 15 : (sel == 1) ? 8 : 21);
    case (sel)
      0: begin a_bcd = b[15:0]; a_start = 1'b1; qa.push_back(e); a_npush++; end
      1: begin b_bcd = b[7:0];  b_start = 1'b1; qb.push_back(e); end
      default: begin c_bcd = b; c_start = 1'b1; qc.push_back(e); end
    endcase
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
    c_start = 1'b0;
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_chk_rdy) begin
      check("a_ready_after_done", {31'd0, a_rdy}, 32'd1);
      a_chk_rdy = 1'b0;
    end
    if (a_done === 1'b1) begin
      a_ndone++;
      if (qa.size() == 0) begin
        fail_event("a_unexpected_done_tick");
      end else begin
        e = qa.pop_front();
        check("a_bin", {18'd0, a_bin}, e.bin);
        check("a_err", {31'd0, a_err}, {31'd0, e.err});
        check("a_latency", cyc - e.issue, e.lat);
        check("a_ready_low_in_done", {31'd0, a_rdy}, 32'd0);
        a_chk_rdy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_done === 1'b1) begin
      if (qb.size() == 0) begin
        fail_event("b_unexpected_done_tick");
      end else begin
        e = qb.pop_front();
        check("b_bin", {25'd0, b_bin}, e.bin);
        check("b_err", {31'd0, b_err}, {31'd0, e.err});
        check("b_latency", cyc - e.issue, e.lat);
        if (b_last >= 0) check("b_done_period", cyc - b_last, 32'd9);
        b_last = cyc;
      end
    end
  end

  always @(negedge clk) begin : mon_c
    exp_t e;
    if (c_done === 1'b1) begin
      if (qc.size() == 0) begin
        fail_event("c_unexpected_done_tick");
      end else begin
        e = qc.pop_front();
        check("c_bin", {12'd0, c_bin}, e.bin);
        check("c_err", {31'd0, c_err}, {31'd0, e.err});
        check("c_latency", cyc - e.issue, e.lat);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin : stim
    bit ok;
    reset   = 1'b1;
    a_start = 1'b0; a_bcd = '0;
    b_start = 1'b0; b_bcd = '0;
    c_start = 1'b0; c_bcd = '0;
    #2;
    check("rst_a_ready", {31'd0, a_rdy}, 32'd1);
    check("rst_a_done",  {31'd0, a_done}, 32'd0);
    check("rst_a_bin",   {18'd0, a_bin}, 32'd0);
    check("rst_a_err",   {31'd0, a_err}, 32'd0);
    check("rst_b_ready", {31'd0, b_rdy}, 32'd1);
    check("rst_c_ready", {31'd0, c_rdy}, 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Full-scale operand, then small/edge values.
    conv(0, 24'h9999, 9999, 1'b0);
    conv(0, 24'h0000, 0, 1'b0);
    conv(0, 24'h0001, 1, 1'b0);
    conv(0, 24'h1000, 1000, 1'b0);
    conv(0, 24'h0512, 512, 1'b0);

    // Invalid digits abort with err and bin cleared; a valid one recovers.
    conv(0, 24'h12A4, 0, 1'b1);
    conv(0, 24'h0042, 42, 1'b0);
    conv(0, 24'hF000, 0, 1'b1);
    conv(0, 24'h0909, 909, 1'b0);

    // A second start while busy must be ignored.
    conv(0, 24'h0321, 321, 1'b0);
    repeat (3) @(negedge clk);
    check("a_ready_busy", {31'd0, a_rdy}, 32'd0);
    a_bcd   = 16'h0777;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;

    // Reset in the middle of OP: aborted conversion produces no done_tick.
    wait_ready(0, ok);
    a_bcd   = 16'h0888;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (4) @(negedge clk);
    check("a_busy_before_reset", {31'd0, a_rdy}, 32'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, a_rdy}, 32'd1);
    check("mid_rst_bin",   {18'd0, a_bin}, 32'd0);
    check("mid_rst_err",   {31'd0, a_err}, 32'd0);
    check("mid_rst_done",  {31'd0, a_done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    conv(0, 24'h0255, 255, 1'b0);

    // Two-digit instance: every value 00..99, back to back.
    for (int v = 0; v < 100; v++) begin
      conv(1, 24'((v / 10) * 16 + (v % 10)), v, 1'b0);
    end

    // Six-digit instance.
    conv(2, 24'h999999, 999999, 1'b0);
    conv(2, 24'h123456, 123456, 1'b0);
    conv(2, 24'h000001, 1, 1'b0);
    conv(2, 24'h9B0000, 0, 1'b1);

    for (int k = 0; k < 100; k++) begin
      if (qa.size() == 0 && qb.size() == 0 && qc.size() == 0) break;
      @(negedge clk);
    end
    if (qa.size() != 0 || qb.size() != 0 || qc.size() != 0) fail_event("drain_timeout");
    repeat (2) @(negedge clk);
    check("a_done_count", a_ndone, a_npush);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
